// File: rtl/dmem_write_arbiter.sv
// rtl/dmem_write_arbiter.sv - data RAM write-port arbiter between core writeback and host loader
//
// Purpose: the core owns the RAM write port by default. A host request is
// served opportunistically on cycles the core does not write. A host refused
// STARVE_LIM consecutive cycles gets a forced burst of up to BURST_MAX writes
// while the core is stalled.
//
// Optional build macro: DMEM_ARB_STATS_EN adds the stall_cycles/host_writes
// saturating counters.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   cpu_we/cpu_addr/cpu_data     core writeback request
//   cpu_stall                    core must hold pc and not write
//   host_req/host_addr/host_data host write request, held until granted
//   host_gnt                     host write committed this cycle
//   mem_we/mem_addr/mem_data     RAM write port
//   stall_cycles, host_writes    statistics (DMEM_ARB_STATS_EN only)
module dmem_write_arbiter #(
   parameter int WORD_W     = 64,
   parameter int ADDR_W     = 20,
   parameter int STARVE_LIM = 8,
   parameter int BURST_MAX  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [WORD_W-1:0] cpu_data,
   output logic              cpu_stall,
   input  logic              host_req,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [WORD_W-1:0] host_data,
   output logic              host_gnt,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_data
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [31:0]       stall_cycles,
   output logic [31:0]       host_writes
`endif
);

   localparam int WCW = $clog2(STARVE_LIM + 1);
   localparam int BCW = $clog2(BURST_MAX + 1);
   localparam logic [WCW-1:0] WAIT_LIM  = WCW'(STARVE_LIM);
   localparam logic [BCW-1:0] BURST_LIM = BCW'(BURST_MAX);

   typedef enum logic {
      S_CORE = 1'b0,
      S_HOST = 1'b1
   } state_e;

   state_e         state_q,     state_d;
   logic [WCW-1:0] wait_cnt_q,  wait_cnt_d;
   logic [BCW-1:0] burst_cnt_q, burst_cnt_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_CORE;
         wait_cnt_q  <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      burst_cnt_d = burst_cnt_q;
      mem_we      = 1'b0;
      mem_addr    = cpu_addr;
      mem_data    = cpu_data;
      host_gnt    = 1'b0;
      cpu_stall   = 1'b0;

      case (state_q)
         S_CORE: begin
            if (cpu_we) begin
               mem_we = 1'b1;
               if (host_req) begin
                  if (wait_cnt_q != WAIT_LIM) begin
                     wait_cnt_d = wait_cnt_q + WCW'(1);
                  end
                  // Decide on the updated count so the burst starts right after
                  // the STARVE_LIM-th refusal, not one cycle later.
                  if (wait_cnt_d == WAIT_LIM) begin
                     state_d     = S_HOST;
                     burst_cnt_d = '0;
                  end
               end else begin
                  wait_cnt_d = '0;
               end
            end else if (host_req) begin
               mem_we     = 1'b1;
               mem_addr   = host_addr;
               mem_data   = host_data;
               host_gnt   = 1'b1;
               wait_cnt_d = '0;
            end else begin
               wait_cnt_d = '0;
            end
         end

         S_HOST: begin
            cpu_stall = 1'b1;
            mem_addr  = host_addr;
            mem_data  = host_data;
            if (host_req) begin
               mem_we      = 1'b1;
               host_gnt    = 1'b1;
               burst_cnt_d = burst_cnt_q + BCW'(1);
               if (burst_cnt_d == BURST_LIM) begin
                  state_d    = S_CORE;
                  wait_cnt_d = '0;
               end
            end else begin
               state_d    = S_CORE;
               wait_cnt_d = '0;
            end
         end

         default: begin
            state_d = S_CORE;
         end
      endcase

      // Reset suppresses every side effect in the same cycle it is seen.
      if (!rst_n) begin
         mem_we    = 1'b0;
         host_gnt  = 1'b0;
         cpu_stall = 1'b0;
      end
   end

`ifdef DMEM_ARB_STATS_EN
   logic [31:0] stall_cycles_q;
   logic [31:0] host_writes_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cycles_q <= '0;
         host_writes_q  <= '0;
      end else begin
         if (cpu_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
         end
         if (host_gnt && (host_writes_q != 32'hFFFF_FFFF)) begin
            host_writes_q <= host_writes_q + 32'd1;
         end
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign host_writes  = host_writes_q;
`else
   // Statistics counters are not built.
`endif

endmodule
